// File: rtl/psum_accum_sfu_if.sv
// Output-FIFO pop side and partial-sum result side of the accumulator.
// slave: the accumulator (pops the FIFO, drives results).
// master: whoever owns the FIFO and consumes the results.
interface psum_accum_sfu_if #(
    parameter int psum_bw = 16,
    parameter int col     = 8
);
    logic                   ofifo_valid_i;
    logic [col*psum_bw-1:0] ofifo_data_i;
    logic                   ofifo_rd_o;
    logic [col*psum_bw-1:0] psum_data_o;
    logic                   psum_data_valid_o;

    modport slave (
        input  ofifo_valid_i,
        input  ofifo_data_i,
        output ofifo_rd_o,
        output psum_data_o,
        output psum_data_valid_o
    );

    modport master (
        output ofifo_valid_i,
        output ofifo_data_i,
        input  ofifo_rd_o,
        input  psum_data_o,
        input  psum_data_valid_o
    );
endinterface

// File: rtl/psum_accum_sfu.sv
// Partial-sum accumulator / special function unit.
// Pops len_onij*n_kij words from a first-word-fall-through output FIFO.
// Each word is summed per lane (signed, saturating) into a per-pixel buffer.
// The buffer is then drained in address order, with optional ReLU.
module psum_accum_sfu #(
    parameter int psum_bw  = 16,
    parameter int col      = 8,
    parameter int len_onij = 16,
    parameter int n_kij    = 9
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic relu_en_i,
    output logic busy_o,
    output logic done_o,
    psum_accum_sfu_if.slave bus
);
    localparam int OW = (len_onij > 1) ? $clog2(len_onij) : 1;
    localparam int KW = (n_kij > 1) ? $clog2(n_kij) : 1;
    localparam logic [OW-1:0] ONIJ_LAST = OW'(len_onij - 1);
    localparam logic [KW-1:0] KIJ_LAST  = KW'(n_kij - 1);
    localparam logic [psum_bw-1:0] SAT_MAX = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] SAT_MIN = {1'b1, {(psum_bw-1){1'b0}}};

    typedef logic [col-1:0][psum_bw-1:0] word_t;
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   onij_cnt_q, onij_cnt_d;
    logic [KW-1:0]   kij_cnt_q, kij_cnt_d;
    logic [OW-1:0]   drain_cnt_q, drain_cnt_d;
    logic            relu_q, relu_d;
    word_t           psum_data_q, psum_data_d;
    logic            psum_valid_q, psum_valid_d;

    // Buffer has no reset: the first kernel position always overwrites.
    word_t           psum_buf_q [len_onij];

    logic            pop;
    word_t           in_word;
    word_t           cur_word;
    word_t           rd_word;
    word_t           acc_d;
    word_t           drain_word;

    // Signed add with clamp: overflow shows as disagreement of the two top bits.
    function automatic logic [psum_bw-1:0] sat_add(input logic [psum_bw-1:0] a,
                                                   input logic [psum_bw-1:0] b);
        logic [psum_bw:0] s;
        s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        if (s[psum_bw] != s[psum_bw-1])
            sat_add = s[psum_bw] ? SAT_MIN : SAT_MAX;
        else
            sat_add = s[psum_bw-1:0];
    endfunction

    assign in_word  = bus.ofifo_data_i;
    assign cur_word = psum_buf_q[onij_cnt_q];
    assign rd_word  = psum_buf_q[drain_cnt_q];
    assign pop      = (state_q == ACCUM) && bus.ofifo_valid_i;

    assign bus.ofifo_rd_o        = pop;
    assign bus.psum_data_o       = psum_data_q;
    assign bus.psum_data_valid_o = psum_valid_q;
    assign busy_o                = (state_q != IDLE);
    assign done_o                = (state_q == DONE);

    // Per-lane accumulate on pop and ReLU on drain.
    always_comb begin
        acc_d      = '0;
        drain_word = '0;
        for (int k = 0; k < col; k++) begin
            acc_d[k]      = (kij_cnt_q == '0) ? in_word[k] : sat_add(cur_word[k], in_word[k]);
            drain_word[k] = (relu_q && rd_word[k][psum_bw-1]) ? '0 : rd_word[k];
        end
    end

    // Next-state, counters and output register inputs.
    always_comb begin
        state_d      = state_q;
        onij_cnt_d   = onij_cnt_q;
        kij_cnt_d    = kij_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        relu_d       = relu_q;
        psum_data_d  = psum_data_q;
        psum_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = ACCUM;
                    onij_cnt_d = '0;
                    kij_cnt_d  = '0;
                    relu_d     = relu_en_i;
                end
            end
            ACCUM: begin
                if (pop) begin
                    if (onij_cnt_q == ONIJ_LAST) begin
                        onij_cnt_d = '0;
                        if (kij_cnt_q == KIJ_LAST) begin
                            state_d     = DRAIN;
                            drain_cnt_d = '0;
                        end else begin
                            kij_cnt_d = kij_cnt_q + 1'b1;
                        end
                    end else begin
                        onij_cnt_d = onij_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                psum_data_d  = drain_word;
                psum_valid_d = 1'b1;
                drain_cnt_d  = drain_cnt_q + 1'b1;
                if (drain_cnt_q == ONIJ_LAST)
                    state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            onij_cnt_q   <= '0;
            kij_cnt_q    <= '0;
            drain_cnt_q  <= '0;
            relu_q       <= 1'b0;
            psum_data_q  <= '0;
            psum_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            onij_cnt_q   <= onij_cnt_d;
            kij_cnt_q    <= kij_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            relu_q       <= relu_d;
            psum_data_q  <= psum_data_d;
            psum_valid_q <= psum_valid_d;
        end
    end

    // Accumulation buffer write on each pop.
    always_ff @(posedge clk) begin
        if (pop)
            psum_buf_q[onij_cnt_q] <= acc_d;
    end
endmodule

// File: tb/tb_psum_accum_sfu.sv
// Randomized scoreboard bench for psum_accum_sfu.
// Expected drain words come from a per-pixel saturating-sum model.
module tb_psum_accum_sfu;
    localparam int BW = 16, COL = 8, LEN = 16, NK = 9, NPOP = LEN * NK;
    localparam int M_ONES = 0, M_MIX = 1, M_SATP = 2, M_SATN = 3, M_TAG = 4, M_RAND = 5;
    typedef logic [COL*BW-1:0] word_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_i = 1'b0;
    logic relu_en_i = 1'b0;
    logic busy_o, done_o;

    psum_accum_sfu_if #(.psum_bw(BW), .col(COL)) bus ();

    psum_accum_sfu #(.psum_bw(BW), .col(COL), .len_onij(LEN), .n_kij(NK)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start_i),
        .relu_en_i (relu_en_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_valid  = 0;
    word_t exp_q [$];
    word_t words [NPOP];

    task automatic check(input string name, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic word_t gen_word(input int mode, input int onij);
        word_t w;
        logic [15:0] v;
        w = '0;
        for (int k = 0; k < COL; k++) begin
            case (mode)
                M_ONES: v = 16'd1;
                M_MIX:  v = (k == 0) ? 16'hFFFB : (k == 7) ? 16'd3 :
                            16'($urandom_range(0, 200)) - 16'd100;
                M_SATP: v = 16'h7000;
                M_SATN: v = 16'h9000;
                M_TAG:  v = (k == 0) ? 16'(onij) : 16'($urandom);
                default: v = 16'($urandom);
            endcase
            w[k*BW +: BW] = v;
        end
        return w;
    endfunction

    // Model: per pixel, first kernel position loads, later ones add with clamp.
    task automatic build_and_expect(input int mode, input bit relu, input bit push);
        int acc [LEN][COL];
        for (int kij = 0; kij < NK; kij++)
            for (int onij = 0; onij < LEN; onij++) begin
                int p;
                p = kij * LEN + onij;
                words[p] = gen_word(mode, onij);
                for (int k = 0; k < COL; k++) begin
                    int v;
                    v = int'($signed(words[p][k*BW +: BW]));
                    if (kij == 0) acc[onij][k] = v;
                    else begin
                        acc[onij][k] = acc[onij][k] + v;
                        if (acc[onij][k] > 32767)  acc[onij][k] = 32767;
                        if (acc[onij][k] < -32768) acc[onij][k] = -32768;
                    end
                end
            end
        if (push)
            for (int onij = 0; onij < LEN; onij++) begin
                word_t e;
                for (int k = 0; k < COL; k++) begin
                    int r;
                    r = (relu && acc[onij][k] < 0) ? 0 : acc[onij][k];
                    e[k*BW +: BW] = 16'(r);
                end
                exp_q.push_back(e);
            end
    endtask

    // Monitor: every valid result is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (bus.psum_data_valid_o === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got %h expected no output", bus.psum_data_o);
            end else begin
                word_t e;
                e = exp_q.pop_front();
                check("psum_out", bus.psum_data_o, e);
            end
        end
    end

    task automatic run_job(input int mode, input bit relu, input bit rnd_valid,
                           input bit inject, input int abort_at);
        int idx, cyc, bad_rd, ndone, nv0;
        bit prev_done;
        idx = 0; cyc = 0; bad_rd = 0; ndone = 0; prev_done = 0;
        build_and_expect(mode, relu, abort_at < 0);
        nv0 = n_valid;
        @(negedge clk);
        start_i = 1'b1; relu_en_i = relu; bus.ofifo_valid_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0; relu_en_i = ~relu;
        while (idx < NPOP && cyc < 4000) begin
            if (abort_at >= 0 && idx == abort_at) break;
            bus.ofifo_valid_i = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.ofifo_data_i  = words[idx];
            start_i = inject && idx >= 50 && idx < 53;
            #1;
            if (bus.ofifo_rd_o && !bus.ofifo_valid_i) bad_rd++;
            if (bus.ofifo_rd_o) idx++;
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        check("rd_only_when_valid", word_t'(bad_rd), '0);
        if (abort_at >= 0) begin
            check("pops_before_abort", word_t'(idx), word_t'(abort_at));
            bus.ofifo_valid_i = 1'b1;
            reset = 1'b1;
            #1;
            check("abort_psum_data", bus.psum_data_o, '0);
            check("abort_valid", word_t'(bus.psum_data_valid_o), '0);
            check("abort_done", word_t'(done_o), '0);
            check("abort_busy", word_t'(busy_o), '0);
            check("abort_rd", word_t'(bus.ofifo_rd_o), '0);
            @(negedge clk); @(negedge clk);
            reset = 1'b0;
            for (int c = 0; c < 20; c++) @(negedge clk);
            check("abort_no_pop", word_t'(bus.ofifo_rd_o), '0);
            check("abort_no_valid", word_t'(n_valid - nv0), '0);
            bus.ofifo_valid_i = 1'b0;
            return;
        end
        bus.ofifo_valid_i = 1'b0;
        check("pop_count", word_t'(idx), word_t'(NPOP));
        for (int c = 0; c < 30; c++) begin
            if (done_o) begin
                ndone++;
                check("valid_with_done", word_t'(bus.psum_data_valid_o), word_t'(1));
            end
            if (prev_done) check("busy_after_done", word_t'(busy_o), '0);
            prev_done = done_o;
            @(negedge clk);
        end
        check("done_pulses", word_t'(ndone), word_t'(1));
        check("drained_words", word_t'(n_valid - nv0), word_t'(LEN));
        check("scoreboard_empty", word_t'(exp_q.size()), '0);
        exp_q.delete();
    endtask

    initial begin
        bus.ofifo_valid_i = 1'b0;
        bus.ofifo_data_i  = '0;
        #3;
        check("reset_psum_data", bus.psum_data_o, '0);
        check("reset_valid", word_t'(bus.psum_data_valid_o), '0);
        check("reset_done", word_t'(done_o), '0);
        check("reset_busy", word_t'(busy_o), '0);
        check("reset_rd", word_t'(bus.ofifo_rd_o), '0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        run_job(M_ONES, 1'b0, 1'b0, 1'b0, -1);
        run_job(M_MIX,  1'b1, 1'b0, 1'b0, -1);
        run_job(M_SATP, 1'b0, 1'b0, 1'b0, -1);
        run_job(M_SATN, 1'b0, 1'b0, 1'b0, -1);
        run_job(M_ONES, 1'b0, 1'b1, 1'b1, -1);
        run_job(M_ONES, 1'b0, 1'b0, 1'b0, 70);
        run_job(M_ONES, 1'b0, 1'b0, 1'b0, -1);
        run_job(M_TAG,  1'b0, 1'b1, 1'b0, -1);
        for (int j = 0; j < 3; j++)
            run_job(M_RAND, 1'($urandom_range(0, 1)), 1'b1, 1'b0, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
